// File: rtl/spike_vote_classifier_if.sv
// Result handshake between the spike vote classifier and its host-side consumer.
// The classifier drives class/count/valid; the consumer answers with ready.
interface spike_vote_classifier_if #(
    parameter int COUNT_WIDTH = 8
);
    logic [3:0]             result_class;
    logic [COUNT_WIDTH-1:0] result_count;
    logic                   result_valid;
    logic                   result_ready;

    modport master (
        output result_class,
        output result_count,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  result_class,
        input  result_count,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/spike_vote_classifier.sv
// Tallies grid output spikes per class (index % NUM_CLASSES) over one frame of ticks,
// then scans the tallies for the winning class and offers it over a valid/ready handshake.
module spike_vote_classifier #(
    parameter int NUM_OUTPUTS     = 250,
    parameter int NUM_CLASSES     = 10,
    parameter int COUNT_WIDTH     = 8,
    parameter int TICKS_PER_FRAME = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            frame_start,
    input  logic                            tick,
    input  logic [7:0]                      packet_out,
    input  logic                            packet_out_valid,
    spike_vote_classifier_if.master         res,
    output logic                            busy,
    output logic                            index_error,
    output logic                            drop_error
);
    localparam int CLS_W  = $clog2(NUM_CLASSES + 1);
    localparam int TICK_W = $clog2(TICKS_PER_FRAME + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, RESULT} state_t;

    state_t                 state_reg, state_next;
    logic [TICK_W-1:0]      tick_cnt_reg;
    logic [CLS_W-1:0]       scan_idx_reg;
    logic [COUNT_WIDTH-1:0] rd_cnt_reg;
    logic [COUNT_WIDTH-1:0] best_cnt_reg;
    logic [3:0]             best_class_reg;
    logic                   index_error_reg;
    logic                   drop_error_reg;
    logic [COUNT_WIDTH-1:0] counter_reg [NUM_CLASSES];

    logic       frame_close;
    logic       spike_in_range;
    logic       spike_ok;
    logic [7:0] spike_class;

    assign frame_close    = (state_reg == ACCUM) && tick &&
                            (tick_cnt_reg == TICK_W'(TICKS_PER_FRAME));
    assign spike_in_range = int'(packet_out) < NUM_OUTPUTS;
    assign spike_ok       = (state_reg == ACCUM) && packet_out_valid && spike_in_range;
    assign spike_class    = 8'(int'(packet_out) % NUM_CLASSES);

    // One saturating vote counter per class; cleared when a frame is armed.
    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_counter
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    counter_reg[gi] <= '0;
                end else if (state_reg == IDLE && frame_start) begin
                    counter_reg[gi] <= '0;
                end else if (spike_ok && spike_class == 8'(gi) && counter_reg[gi] != '1) begin
                    counter_reg[gi] <= counter_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (frame_start) state_next = ACCUM;
            ACCUM:   if (frame_close) state_next = ARGMAX;
            ARGMAX:  if (scan_idx_reg == CLS_W'(NUM_CLASSES)) state_next = RESULT;
            RESULT:  if (res.result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The scan reads one counter per cycle into rd_cnt_reg and compares it on the
    // following cycle, so the comparison trails scan_idx_reg by one class.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            tick_cnt_reg    <= '0;
            scan_idx_reg    <= '0;
            rd_cnt_reg      <= '0;
            best_cnt_reg    <= '0;
            best_class_reg  <= '0;
            index_error_reg <= 1'b0;
            drop_error_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (frame_start) tick_cnt_reg <= '0;
                end
                ACCUM: begin
                    if (frame_close) begin
                        scan_idx_reg   <= '0;
                        best_cnt_reg   <= '0;
                        best_class_reg <= '0;
                    end else if (tick) begin
                        tick_cnt_reg <= tick_cnt_reg + 1'b1;
                    end
                end
                ARGMAX: begin
                    if (scan_idx_reg < CLS_W'(NUM_CLASSES)) begin
                        rd_cnt_reg   <= counter_reg[scan_idx_reg];
                        scan_idx_reg <= scan_idx_reg + 1'b1;
                    end
                    // Strict compare keeps the lowest class index on a tie.
                    if (scan_idx_reg != '0 && rd_cnt_reg > best_cnt_reg) begin
                        best_cnt_reg   <= rd_cnt_reg;
                        best_class_reg <= 4'(scan_idx_reg - CLS_W'(1));
                    end
                end
                default: ;
            endcase
            if (packet_out_valid && state_reg == ACCUM && !spike_in_range) index_error_reg <= 1'b1;
            if (packet_out_valid && state_reg != ACCUM) drop_error_reg <= 1'b1;
        end
    end

    assign busy             = (state_reg != IDLE);
    assign index_error      = index_error_reg;
    assign drop_error       = drop_error_reg;
    assign res.result_valid = (state_reg == RESULT);
    assign res.result_class = best_class_reg;
    assign res.result_count = best_cnt_reg;
endmodule

// File: tb/tb_spike_vote_classifier.sv
// Directed bench for spike_vote_classifier: frames of hand-picked spikes with
// hand-computed winners, saturation, error flags, back-pressure and mid-frame reset.
module tb_spike_vote_classifier;
    localparam int NO  = 250;
    localparam int NC  = 10;
    localparam int CW  = 8;
    localparam int TPF = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] packet_out = '0;
    logic       packet_out_valid = 1'b0;
    logic       busy, index_error, drop_error;

    int vec_count = 0;
    int miscompares = 0;

    spike_vote_classifier_if #(.COUNT_WIDTH(CW)) res_if ();

    spike_vote_classifier #(
        .NUM_OUTPUTS(NO), .NUM_CLASSES(NC), .COUNT_WIDTH(CW), .TICKS_PER_FRAME(TPF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .tick(tick),
        .packet_out(packet_out), .packet_out_valid(packet_out_valid), .res(res_if),
        .busy(busy), .index_error(index_error), .drop_error(drop_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // All drive tasks start and end just after a falling edge.
    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic spike(input int idx);
        packet_out = 8'(idx);
        packet_out_valid = 1'b1;
        @(negedge clk);
        packet_out_valid = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic close_frame();
        for (int i = 0; i < TPF + 1; i++) do_tick();
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!res_if.result_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept();
        res_if.result_ready = 1'b1;
        @(negedge clk);
        res_if.result_ready = 1'b0;
    endtask

    initial begin
        int lat;
        res_if.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_valid", 32'(res_if.result_valid), 0);
        check_val("rst_class", 32'(res_if.result_class), 0);
        check_val("rst_count", 32'(res_if.result_count), 0);
        check_val("rst_idx_err", 32'(index_error), 0);
        check_val("rst_drop_err", 32'(drop_error), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Frame 1: three spikes on class 3
        start_frame();
        check_val("t1_busy", 32'(busy), 1);
        spike(3); spike(13); spike(23);
        close_frame();
        wait_result(lat);
        check_val("t1_latency", 32'(lat), 11);
        check_val("t1_class", 32'(res_if.result_class), 3);
        check_val("t1_count", 32'(res_if.result_count), 3);
        accept();
        check_val("t1_busy_after", 32'(busy), 0);
        check_val("t1_valid_after", 32'(res_if.result_valid), 0);

        // Frame 2: tie between class 1 and 4, with an ignored frame_start mid-frame
        start_frame();
        spike(1); spike(4);
        start_frame();
        spike(1); spike(4);
        close_frame();
        wait_result(lat);
        check_val("t2_class", 32'(res_if.result_class), 1);
        check_val("t2_count", 32'(res_if.result_count), 2);
        accept();

        // Frame 3: 300 spikes on idx 7 saturate at 255
        start_frame();
        for (int i = 0; i < 300; i++) spike(7);
        close_frame();
        wait_result(lat);
        check_val("t3_class", 32'(res_if.result_class), 7);
        check_val("t3_count", 32'(res_if.result_count), 255);
        accept();

        // Frame 4: out-of-range idx 250 must not land on class 0 (would win the tie vs class 5)
        start_frame();
        spike(5);
        check_val("t4_idx_err_pre", 32'(index_error), 0);
        spike(250);
        check_val("t4_idx_err", 32'(index_error), 1);
        close_frame();
        wait_result(lat);
        check_val("t4_class", 32'(res_if.result_class), 5);
        check_val("t4_count", 32'(res_if.result_count), 1);
        accept();
        check_val("t4_drop_err_pre", 32'(drop_error), 0);
        spike(2);
        check_val("t4_drop_err", 32'(drop_error), 1);

        // Frame 5: back-pressure holds the result
        start_frame();
        spike(2); spike(2); spike(12); spike(22);
        close_frame();
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            check_val("t5_hold_valid", 32'(res_if.result_valid), 1);
            check_val("t5_hold_class", 32'(res_if.result_class), 2);
            @(negedge clk);
        end
        check_val("t5_count", 32'(res_if.result_count), 4);
        accept();
        check_val("t5_busy_after", 32'(busy), 0);
        check_val("t5_valid_after", 32'(res_if.result_valid), 0);

        // Frame 6: reset mid-ACCUM abandons the frame and clears sticky errors
        start_frame();
        spike(8);
        do_tick();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_val("t6_busy", 32'(busy), 0);
        check_val("t6_valid", 32'(res_if.result_valid), 0);
        check_val("t6_idx_err", 32'(index_error), 0);
        check_val("t6_drop_err", 32'(drop_error), 0);
        check_val("t6_count_rst", 32'(res_if.result_count), 0);
        start_frame();
        spike(9);
        close_frame();
        wait_result(lat);
        check_val("t6_latency", 32'(lat), 11);
        check_val("t6_class", 32'(res_if.result_class), 9);
        check_val("t6_count", 32'(res_if.result_count), 1);
        accept();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
